// File: rtl/mem_loader.sv
// Host-side loader: streams words into instruction/data memory, then releases the CPU.
// Define MEM_LOADER_DUMP_EN to build the data-memory readback path.
module mem_loader #(
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned DMEM_DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        start_i,
    input  logic [9:0]  imem_words_i,
    input  logic [10:0] dmem_words_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [63:0] s_data_i,
    input  logic        dump_start_i,
    input  logic [10:0] dump_words_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [63:0] m_data_o,
    output logic [63:0] addr_ext_o,
    output logic        wen_ext_o,
    output logic        ren_ext_o,
    output logic [31:0] wdata_ext_o,
    output logic [63:0] addr_ext_2_o,
    output logic        wen_ext_2_o,
    output logic        ren_ext_2_o,
    output logic [63:0] wdata_ext_2_o,
    input  logic [63:0] rdata_ext_2_i,
    output logic        cpu_enable_o,
    output logic        busy_o
);

    localparam logic [10:0] ImemMax = 11'(IMEM_DEPTH);
    localparam logic [10:0] DmemMax = 11'(DMEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StLoadI, StLoadD, StSettle, StRun
`ifdef MEM_LOADER_DUMP_EN
        , StDumpRd, StDumpOut
`endif
    } state_e;

    state_e      state_q;
    logic [10:0] cnt_q, imem_n_q, dmem_n_q;
    logic [10:0] cnt_inc, imem_clamp, dmem_clamp;

    assign cnt_inc    = cnt_q + 11'd1;
    assign imem_clamp = ({1'b0, imem_words_i} > ImemMax) ? ImemMax : {1'b0, imem_words_i};
    assign dmem_clamp = (dmem_words_i > DmemMax) ? DmemMax : dmem_words_i;

    assign s_ready_o = (state_q == StLoadI) || (state_q == StLoadD);
    assign busy_o    = !((state_q == StIdle) || (state_q == StRun));
    assign ren_ext_o = 1'b0;

`ifdef MEM_LOADER_DUMP_EN
    logic [10:0] dump_n_q, dump_clamp;
    logic        m_valid_q, ren_2_q, first_q;
    logic [63:0] m_data_q;

    assign dump_clamp = (dump_words_i > DmemMax) ? DmemMax : dump_words_i;
    assign m_valid_o  = m_valid_q;
    assign ren_ext_2_o = ren_2_q;
    // Read data arrives in the first DUMP_OUT cycle; it is registered there and held afterwards.
    assign m_data_o   = first_q ? rdata_ext_2_i : m_data_q;
`else
    logic unused_dump;
    assign unused_dump = ^{dump_start_i, dump_words_i, m_ready_i, rdata_ext_2_i};
    assign m_valid_o   = 1'b0;
    assign m_data_o    = '0;
    assign ren_ext_2_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            imem_n_q      <= '0;
            dmem_n_q      <= '0;
            addr_ext_o    <= '0;
            wen_ext_o     <= 1'b0;
            wdata_ext_o   <= '0;
            addr_ext_2_o  <= '0;
            wen_ext_2_o   <= 1'b0;
            wdata_ext_2_o <= '0;
            cpu_enable_o  <= 1'b0;
`ifdef MEM_LOADER_DUMP_EN
            dump_n_q      <= '0;
            m_valid_q     <= 1'b0;
            ren_2_q       <= 1'b0;
            first_q       <= 1'b0;
            m_data_q      <= '0;
`endif
        end else begin
            wen_ext_o   <= 1'b0;
            wen_ext_2_o <= 1'b0;
`ifdef MEM_LOADER_DUMP_EN
            ren_2_q     <= 1'b0;
`endif
            unique case (state_q)
                StIdle, StRun: begin
                    if (start_i) begin
                        imem_n_q     <= imem_clamp;
                        dmem_n_q     <= dmem_clamp;
                        cnt_q        <= '0;
                        cpu_enable_o <= 1'b0;
                        if (imem_clamp != '0)      state_q <= StLoadI;
                        else if (dmem_clamp != '0) state_q <= StLoadD;
                        else                       state_q <= StSettle;
                    end
`ifdef MEM_LOADER_DUMP_EN
                    else if (dump_start_i) begin
                        dump_n_q     <= dump_clamp;
                        cnt_q        <= '0;
                        cpu_enable_o <= 1'b0;
                        if (dump_clamp != '0) begin
                            state_q      <= StDumpRd;
                            ren_2_q      <= 1'b1;
                            addr_ext_2_o <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
`endif
                end
                StLoadI: begin
                    if (s_valid_i) begin
                        wen_ext_o   <= 1'b1;
                        addr_ext_o  <= {51'd0, cnt_q, 2'b00};
                        wdata_ext_o <= s_data_i[31:0];
                        if (cnt_inc == imem_n_q) begin
                            cnt_q   <= '0;
                            state_q <= (dmem_n_q != '0) ? StLoadD : StSettle;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StLoadD: begin
                    if (s_valid_i) begin
                        wen_ext_2_o   <= 1'b1;
                        addr_ext_2_o  <= {50'd0, cnt_q, 3'b000};
                        wdata_ext_2_o <= s_data_i;
                        if (cnt_inc == dmem_n_q) begin
                            cnt_q   <= '0;
                            state_q <= StSettle;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StSettle: begin
                    cpu_enable_o <= 1'b1;
                    state_q      <= StRun;
                end
`ifdef MEM_LOADER_DUMP_EN
                StDumpRd: begin
                    state_q   <= StDumpOut;
                    m_valid_q <= 1'b1;
                    first_q   <= 1'b1;
                end
                StDumpOut: begin
                    first_q <= 1'b0;
                    if (first_q) m_data_q <= rdata_ext_2_i;
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        if (cnt_inc == dump_n_q) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q        <= cnt_inc;
                            state_q      <= StDumpRd;
                            ren_2_q      <= 1'b1;
                            addr_ext_2_o <= {50'd0, cnt_inc, 3'b000};
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader; covers the dump path when MEM_LOADER_DUMP_EN is set.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        arst, start, s_valid, s_ready, dump_start, m_valid, m_ready;
    logic [9:0]  imem_words;
    logic [10:0] dmem_words, dump_words;
    logic [63:0] s_data, m_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy;
    logic [31:0] wdata_ext;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    logic [63:0] words [5];
    logic [63:0] dmem [1024];

    mem_loader dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .start_i      (start),
        .imem_words_i (imem_words),
        .dmem_words_i (dmem_words),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .dump_start_i (dump_start),
        .dump_words_i (dump_words),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .addr_ext_o   (addr_ext),
        .wen_ext_o    (wen_ext),
        .ren_ext_o    (ren_ext),
        .wdata_ext_o  (wdata_ext),
        .addr_ext_2_o (addr_ext_2),
        .wen_ext_2_o  (wen_ext_2),
        .ren_ext_2_o  (ren_ext_2),
        .wdata_ext_2_o(wdata_ext_2),
        .rdata_ext_2_i(rdata_ext_2),
        .cpu_enable_o (cpu_enable),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Data memory model with one cycle of read latency.
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    always @(negedge clk) if (wen_ext_2 && ren_ext_2) overlap++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write for stream word i of the 3+2 basic load.
    task automatic exp_write(input int i);
        if (i < 3) begin
            chk1("wen_ext", wen_ext, 1'b1);
            chk1("wen_ext_2 idle", wen_ext_2, 1'b0);
            chk("addr_ext", addr_ext, 64'(4 * i));
            chk("wdata_ext", 64'(wdata_ext), words[i] & 64'hFFFF_FFFF);
        end else begin
            chk1("wen_ext_2", wen_ext_2, 1'b1);
            chk1("wen_ext idle", wen_ext, 1'b0);
            chk("addr_ext_2", addr_ext_2, 64'(8 * (i - 3)));
            chk("wdata_ext_2", wdata_ext_2, words[i]);
        end
    endtask

    initial begin
        int nw, bad;
        logic [63:0] last;
        words[0] = 64'h0050_0093;
        words[1] = 64'h00A0_0113;
        words[2] = 64'h0020_81B3;
        words[3] = 64'h11;
        words[4] = 64'h22;
        arst = 1'b1; start = 1'b0; s_valid = 1'b0; dump_start = 1'b0; m_ready = 1'b0;
        imem_words = '0; dmem_words = '0; dump_words = '0; s_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst wen_ext", wen_ext, 1'b0);
        chk1("rst ren_ext", ren_ext, 1'b0);
        chk1("rst wen_ext_2", wen_ext_2, 1'b0);
        chk1("rst ren_ext_2", ren_ext_2, 1'b0);
        chk("rst addr_ext", addr_ext, 64'd0);
        chk("rst addr_ext_2", addr_ext_2, 64'd0);
        chk1("rst m_valid", m_valid, 1'b0);
        chk("rst m_data", m_data, 64'd0);
        chk1("rst cpu_enable", cpu_enable, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst s_ready", s_ready, 1'b0);
        arst = 1'b0;

        // Basic load, s_valid held high
        start = 1'b1; imem_words = 10'd3; dmem_words = 11'd2;
        tick();
        start = 1'b0;
        chk1("load s_ready", s_ready, 1'b1);
        chk1("load busy", busy, 1'b1);
        chk1("load wen idle", wen_ext, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = words[i];
            tick();
            exp_write(i);
            if (i < 4) chk1("load cpu_enable low", cpu_enable, 1'b0);
        end
        s_valid = 1'b0;
        chk1("settle s_ready", s_ready, 1'b0);
        chk1("settle busy", busy, 1'b1);
        tick();
        chk1("run cpu_enable", cpu_enable, 1'b1);
        chk1("run busy", busy, 1'b0);
        chk1("run no write", wen_ext_2, 1'b0);
        chk("dmem[1]", dmem[1], 64'h22);

        // Stalled stream; a start pulse during the load must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("stall cpu_enable drop", cpu_enable, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b0;
            if (i == 1) begin
                start = 1'b1; imem_words = 10'd0; dmem_words = 11'd0;
            end
            tick();
            start = 1'b0; imem_words = 10'd3; dmem_words = 11'd2;
            chk1("stall no wen_ext", wen_ext, 1'b0);
            chk1("stall no wen_ext_2", wen_ext_2, 1'b0);
            chk1("stall s_ready", s_ready, 1'b1);
            s_valid = 1'b1; s_data = words[i];
            tick();
            exp_write(i);
        end
        s_valid = 1'b0;
        tick();
        chk1("stall run cpu_enable", cpu_enable, 1'b1);

        // Zero counts: start -> SETTLE -> RUN
        start = 1'b1; imem_words = 10'd0; dmem_words = 11'd0;
        tick();
        start = 1'b0;
        chk1("zero settle busy", busy, 1'b1);
        chk1("zero settle s_ready", s_ready, 1'b0);
        chk1("zero settle cpu_enable", cpu_enable, 1'b0);
        chk1("zero no wen_ext", wen_ext, 1'b0);
        chk1("zero no wen_ext_2", wen_ext_2, 1'b0);
        tick();
        chk1("zero run cpu_enable", cpu_enable, 1'b1);
        chk1("zero no wen late", wen_ext, 1'b0);

        // Oversized instruction count clamps to 512 words
        start = 1'b1; imem_words = 10'd600; dmem_words = 11'd0;
        tick();
        start = 1'b0;
        nw = 0; bad = 0; last = '0;
        s_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            s_data = 64'(i);
            tick();
            if (wen_ext) begin
                if (addr_ext !== 64'(4 * nw)) bad++;
                nw++;
                last = addr_ext;
            end
        end
        s_valid = 1'b0;
        chk("clamp write count", 64'(nw), 64'd512);
        chk("clamp last addr", last, 64'h7FC);
        chk("clamp addr errors", 64'(bad), 64'd0);
        chk1("clamp cpu_enable", cpu_enable, 1'b1);

        // Reset mid-load after two accepted words
        start = 1'b1; imem_words = 10'd5; dmem_words = 11'd0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'hAAAA;
        tick();
        s_data = 64'hBBBB;
        tick();
        chk("pre-reset addr_ext", addr_ext, 64'd4);
        arst = 1'b1;
        #1;
        chk1("arst wen_ext", wen_ext, 1'b0);
        chk("arst addr_ext", addr_ext, 64'd0);
        chk("arst wdata_ext", 64'(wdata_ext), 64'd0);
        chk1("arst busy", busy, 1'b0);
        chk1("arst s_ready", s_ready, 1'b0);
        chk1("arst cpu_enable", cpu_enable, 1'b0);
        s_valid = 1'b0;
        tick();
        arst = 1'b0;
        start = 1'b1; imem_words = 10'd1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'hCCCC;
        tick();
        s_valid = 1'b0;
        chk1("restart wen_ext", wen_ext, 1'b1);
        chk("restart addr_ext", addr_ext, 64'd0);
        chk("restart wdata_ext", 64'(wdata_ext), 64'hCCCC);
        tick();
        tick();
        chk1("restart cpu_enable", cpu_enable, 1'b1);

`ifdef MEM_LOADER_DUMP_EN
        // Preload dmem[0..3] = 1..4 with no instruction words
        start = 1'b1; imem_words = 10'd0; dmem_words = 11'd4;
        tick();
        start = 1'b0;
        chk1("preload s_ready", s_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 64'(k + 1);
            tick();
            chk("preload addr_ext_2", addr_ext_2, 64'(8 * k));
        end
        s_valid = 1'b0;
        tick();
        chk1("preload cpu_enable", cpu_enable, 1'b1);

        // Dump four words with backpressure on the first
        dump_start = 1'b1; dump_words = 11'd4; m_ready = 1'b0;
        tick();
        dump_start = 1'b0;
        chk1("dump cpu_enable drop", cpu_enable, 1'b0);
        chk1("dump ren_ext_2", ren_ext_2, 1'b1);
        chk("dump rd addr0", addr_ext_2, 64'd0);
        chk1("dump rd m_valid", m_valid, 1'b0);
        tick();
        chk1("dump m_valid", m_valid, 1'b1);
        chk("dump m_data 1", m_data, 64'd1);
        chk1("dump out ren low", ren_ext_2, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk1("dump hold m_valid", m_valid, 1'b1);
            chk("dump hold m_data", m_data, 64'd1);
        end
        m_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk1("dump rd m_valid low", m_valid, 1'b0);
            chk1("dump rd ren", ren_ext_2, 1'b1);
            chk("dump rd addr", addr_ext_2, 64'(8 * (k - 1)));
            tick();
            chk1("dump out m_valid", m_valid, 1'b1);
            chk("dump out m_data", m_data, 64'(k));
        end
        tick();
        m_ready = 1'b0;
        chk1("dump end busy", busy, 1'b0);
        chk1("dump end m_valid", m_valid, 1'b0);
        chk1("dump end cpu_enable", cpu_enable, 1'b0);

        // start beats dump_start; dump_start during a load is ignored
        start = 1'b1; imem_words = 10'd1; dmem_words = 11'd0;
        dump_start = 1'b1; dump_words = 11'd2;
        tick();
        start = 1'b0;
        chk1("tie s_ready", s_ready, 1'b1);
        chk1("tie ren_ext_2", ren_ext_2, 1'b0);
        tick();
        dump_start = 1'b0;
        chk1("busy dump ignored s_ready", s_ready, 1'b1);
        chk1("busy dump ignored ren", ren_ext_2, 1'b0);
        s_valid = 1'b1; s_data = 64'h99;
        tick();
        s_valid = 1'b0;
        chk("tie write addr", addr_ext, 64'd0);
        chk("tie write data", 64'(wdata_ext), 64'h99);
        tick();
        tick();
        chk1("tie cpu_enable", cpu_enable, 1'b1);
`else
        // Without the dump path, dump_start in RUN has no effect
        dump_start = 1'b1; dump_words = 11'd4; m_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        chk1("nodump cpu_enable", cpu_enable, 1'b1);
        chk1("nodump m_valid", m_valid, 1'b0);
        chk1("nodump ren_ext_2", ren_ext_2, 1'b0);
        chk1("nodump busy", busy, 1'b0);
        tick();
        chk1("nodump cpu_enable later", cpu_enable, 1'b1);
        chk1("nodump m_valid later", m_valid, 1'b0);
        chk1("nodump ren_ext_2 later", ren_ext_2, 1'b0);
`endif

        chk("ren/wen overlap cycles", 64'(overlap), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Host-side initiator for the processor's external memory ports. It accepts a valid/ready word stream, writes it into instruction memory and then data memory through the `*_ext` / `*_ext_2` ports, and releases the processor by driving its `enable`. On request it holds the processor and streams a range of data memory back out on a second valid/ready interface. It sits between the testbench/host link and the top-level `cpu`.

## Interface
- `IMEM_DEPTH`, 512: instruction memory size in 32-bit words.
- `DMEM_DEPTH`, 1024: data memory size in 64-bit words.
- `clk` in 1: clock. Everything is rising-edge.
- `arst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a load. Ignored unless the FSM is in IDLE or RUN.
- `imem_words` in 10: number of instruction words to load. Sampled on `start`.
- `dmem_words` in 11: number of data words to load. Sampled on `start`.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 64: load stream. Instruction words use `s_data[31:0]`.
- `dump_start` in 1: single-cycle pulse that begins a readback. Ignored unless the FSM is in IDLE or RUN.
- `dump_words` in 11: number of data words to read back. Sampled on `dump_start`.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 64: readback stream.
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32: instruction memory port. `ren_ext` is tied to 0.
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64: data memory port.
- `cpu_enable` out 1: drives the processor `enable`.
- `busy` out 1: high in any state other than IDLE and RUN.

## Operation
- States: IDLE, LOAD_I, LOAD_D, SETTLE, RUN, DUMP_RD, DUMP_OUT.
- Reset state is IDLE. At reset every output is 0, all counters are 0, and `addr_*` is 0.
- `start` behaviour:
  - Latches `min(imem_words, IMEM_DEPTH)` and `min(dmem_words, DMEM_DEPTH)`.
  - Clears the word counter and drops `cpu_enable`.
  - Goes to LOAD_I. A count of 0 skips that phase; if both counts are 0 the FSM goes straight to SETTLE.
- LOAD_I and LOAD_D:
  - `s_ready` is 1 in these states.
  - Each `s_valid & s_ready` cycle produces one registered write in the following cycle. LOAD_I writes `addr_ext = 4*k`, `wdata_ext = s_data[31:0]`, `wen_ext = 1`. LOAD_D writes `addr_ext_2 = 8*k`, `wdata_ext_2 = s_data`, `wen_ext_2 = 1`.
  - `k` counts accepted words in the current phase and resets to 0 when the phase changes.
  - The handshake that accepts the last word of a phase moves the FSM to the next phase, or to SETTLE.
- SETTLE: lasts exactly one cycle. The final write is issued in this cycle; the FSM then enters RUN.
- RUN: `cpu_enable = 1`. The FSM stays here until `start` or `dump_start`.
- Readback:
  - `dump_start` drops `cpu_enable` in the next cycle, latches `min(dump_words, DMEM_DEPTH)`, and goes to DUMP_RD. If the count is 0 the FSM goes directly to IDLE.
  - DUMP_RD issues one cycle with `ren_ext_2 = 1` and `addr_ext_2 = 8*k`, then goes to DUMP_OUT.
  - DUMP_OUT captures `rdata_ext_2` into `m_data` on entry (the memory has one cycle of read latency) and holds `m_valid = 1` with `m_data` stable until `m_ready`.
  - On the `m_ready` handshake the FSM returns to DUMP_RD, or to IDLE after the last word.
- `wen_ext_2` and `ren_ext_2` are never high in the same cycle.
- All `wen_*` and `ren_*` outputs are 0 in every cycle that carries no access.

## Timing
- Load throughput is one word per cycle. A handshake in cycle N produces the write strobe in cycle N+1.
- For the last load handshake in cycle N: the final write is in N+1 (SETTLE) and `cpu_enable` rises in N+2.
- The first readback word is valid 2 cycles after `dump_start` is sampled. Each subsequent word takes at least 2 cycles (DUMP_RD plus DUMP_OUT).
- While `s_valid` is low, the FSM holds its state and counter and issues no write.
- Simultaneous `start` and `dump_start`: `start` wins.
- `start` or `dump_start` outside IDLE or RUN is ignored.
- `arst` mid-operation returns to IDLE in the same cycle with all outputs 0. A partial load is not resumed.
- Address arithmetic is done in 64 bits. Counters are 11 bits and never exceed the clamped count, so addresses never wrap.

## Configuration
- `MEM_LOADER_DUMP_EN` defined: the readback path (DUMP_RD, DUMP_OUT, `m_*`, `ren_ext_2`) is built as described above.
- Not defined:
  - `dump_start` is ignored and the states DUMP_RD and DUMP_OUT are absent.
  - `m_valid`, `m_data` and `ren_ext_2` are tied to 0.
  - `m_ready` and `rdata_ext_2` are unused.

## Test plan
- Basic load: `start` with `imem_words = 3`, `dmem_words = 2`; stream `0x00500093`, `0x00A00113`, `0x002081B3`, `0x11`, `0x22` with `s_valid` held high. Expect `wen_ext` at addresses 0, 4, 8, then `wen_ext_2` at 0, 8 with data `0x11`, `0x22`. `cpu_enable` rises 2 cycles after the last handshake.
- Stalled stream: same load with `s_valid` low on alternating cycles. Expect an identical write sequence and no write in any cycle that follows a cycle without a handshake.
- Zero counts: `start` with both counts 0 → IDLE → SETTLE → RUN, `cpu_enable = 1` on the third cycle, and no write strobes. `imem_words = 600` → exactly 512 writes, the last at address `0x7FC`.
- Dump with backpressure:
  - Preload `dmem[0..3] = 1, 2, 3, 4`; in RUN pulse `dump_start` with `dump_words = 4` and `m_ready` low for 3 cycles.
  - Expect `cpu_enable` to drop, `m_data = 1` held stable, then 2, 3, 4, then IDLE.
  - `ren_ext_2` must never coincide with `wen_ext_2`.
- Reset mid-load: assert `arst` after 2 of 5 words have been accepted. Outputs go to 0 immediately; a new `start` restarts at address 0.
- Build without `MEM_LOADER_DUMP_EN`: `dump_start` in RUN leaves `cpu_enable = 1`, and `m_valid` and `ren_ext_2` stay 0.
